// File: rtl/gray_to_rgb565_expander.sv
// Streaming expander: one 32-bit word of four 8-bit gray pixels becomes two
// 32-bit words of two RGB565 pixels each, with valid/ready on both sides.
module gray_to_rgb565_expander #(
    parameter bit          SWAP_BYTES  = 1'b0,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   nReset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [COUNT_WIDTH-1:0] pixel_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_LOW   = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [31:0]            hold;
    logic [31:0]            hold_nxt;
    logic [COUNT_WIDTH-1:0] count_nxt;
    logic                   in_fire;
    logic                   out_fire;

    // Truncating gray -> RGB565, optionally byte-swapped for the big-endian path
    function automatic logic [15:0] to_rgb565(input logic [7:0] g);
        logic [15:0] px;
        px = {g[7:3], g[7:2], g[7:3]};
        if (SWAP_BYTES) begin
            px = {px[7:0], px[15:8]};
        end
        return px;
    endfunction

    // Output side decodes only registered state and hold
    always_comb begin
        out_valid = 1'b0;
        out_data  = 32'd0;
        case (state)
            ST_LOW: begin
                out_valid = 1'b1;
                out_data  = {to_rgb565(hold[15:8]), to_rgb565(hold[7:0])};
            end
            ST_HIGH: begin
                out_valid = 1'b1;
                out_data  = {to_rgb565(hold[31:24]), to_rgb565(hold[23:16])};
            end
            default: begin
                out_valid = 1'b0;
                out_data  = 32'd0;
            end
        endcase
    end

    assign in_ready = nReset & ~clear &
                      ((state == ST_EMPTY) | ((state == ST_HIGH) & out_ready));
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state, hold and counter update
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        count_nxt = pixel_count;
        if (in_fire) begin
            hold_nxt = in_data;
        end
        if (clear) begin
            state_nxt = ST_EMPTY;
            count_nxt = '0;
        end else begin
            if (out_fire) begin
                count_nxt = pixel_count + COUNT_WIDTH'(2);
            end
            case (state)
                ST_EMPTY: if (in_fire) state_nxt = ST_LOW;
                ST_LOW:   if (out_fire) state_nxt = ST_HIGH;
                ST_HIGH:  if (out_fire) state_nxt = in_fire ? ST_LOW : ST_EMPTY;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state       <= ST_EMPTY;
            hold        <= 32'd0;
            pixel_count <= '0;
        end else begin
            state       <= state_nxt;
            hold        <= hold_nxt;
            pixel_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_gray_to_rgb565_expander.sv
// Randomized bench: a queue-based model of the expected output stream, checked
// on two instances (straight 32-bit counter, and byte-swapped 4-bit counter).
module tb_gray_to_rgb565_expander;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b0;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_data0, out_data1;
    logic [31:0] pixel_count0;
    logic [3:0]  pixel_count1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] cnt_m = 32'd0;

    always #5 clk = ~clk;

    gray_to_rgb565_expander #(.SWAP_BYTES(1'b0), .COUNT_WIDTH(32)) dut0 (
        .clock(clk), .nReset(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .pixel_count(pixel_count0)
    );

    gray_to_rgb565_expander #(.SWAP_BYTES(1'b1), .COUNT_WIDTH(4)) dut1 (
        .clock(clk), .nReset(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .pixel_count(pixel_count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference pixel from arithmetic on the gray value
    function automatic int ref_px(input int g, input bit swap);
        int r, gg, p;
        r  = g / 8;
        gg = g / 4;
        p  = r * 2048 + gg * 32 + r;
        if (swap) p = (p % 256) * 256 + p / 256;
        return p;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] d, input int pair, input bit swap);
        int lo, hi;
        lo = ref_px(int'((d >> (16 * pair)) & 32'hFF), swap);
        hi = ref_px(int'((d >> (16 * pair + 8)) & 32'hFF), swap);
        return 32'(hi * 65536 + lo);
    endfunction

    // One clock cycle: drive at negedge, check just after, then update the model
    task automatic step(input logic v, input logic [31:0] d, input logic ordy, input logic clr);
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        #1;
        exp_rdy = !clr && (exp0_q.size() == 0 || (exp0_q.size() == 1 && ordy));
        check("in_ready0", 32'(in_ready0), 32'(exp_rdy));
        check("in_ready1", 32'(in_ready1), 32'(exp_rdy));
        check("out_valid0", 32'(out_valid0), 32'(exp0_q.size() != 0));
        check("out_valid1", 32'(out_valid1), 32'(exp1_q.size() != 0));
        if (exp0_q.size() != 0) begin
            check("out_data0", out_data0, exp0_q[0]);
            check("out_data1", out_data1, exp1_q[0]);
        end
        check("pixel_count0", pixel_count0, cnt_m);
        check("pixel_count1", 32'(pixel_count1), cnt_m % 16);
        if (clr) begin
            exp0_q.delete();
            exp1_q.delete();
            cnt_m = 32'd0;
        end else begin
            if (exp0_q.size() != 0 && ordy) begin
                void'(exp0_q.pop_front());
                void'(exp1_q.pop_front());
                cnt_m = cnt_m + 32'd2;
            end
            if (v && exp_rdy) begin
                exp0_q.push_back(ref_word(d, 0, 1'b0));
                exp0_q.push_back(ref_word(d, 1, 1'b0));
                exp1_q.push_back(ref_word(d, 0, 1'b1));
                exp1_q.push_back(ref_word(d, 1, 1'b1));
            end
        end
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_out_valid0"}, 32'(out_valid0), 32'd0);
        check({tag, "_out_valid1"}, 32'(out_valid1), 32'd0);
        check({tag, "_out_data0"}, out_data0, 32'd0);
        check({tag, "_out_data1"}, out_data1, 32'd0);
        check({tag, "_in_ready0"}, 32'(in_ready0), 32'd0);
        check({tag, "_count0"}, pixel_count0, 32'd0);
        check({tag, "_count1"}, 32'(pixel_count1), 32'd0);
    endtask

    initial begin
        #3;
        check_in_reset("por");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Basic conversion with literal expectations
        step(1'b1, 32'h1280FF00, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("basic_w0", out_data0, 32'hFFFF0000);
        check("basic_w0_swap", out_data1, 32'hFFFF0000);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("basic_w1", out_data0, 32'h10828410);
        check("basic_w1_swap", out_data1, 32'h82101084);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("basic_count", pixel_count0, 32'd4);

        // Streaming: in_valid and out_ready held high
        for (int i = 0; i < 17; i++) step(1'b1, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Backpressure in LOW for five cycles
        step(1'b1, 32'hA5C3_7E18, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Clear while presenting the high half
        step(1'b1, $urandom, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b1, $urandom, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("clear_count", pixel_count0, 32'd0);

        // Asynchronous reset mid-word, between edges
        step(1'b1, 32'h11223344, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_in_reset("async");
        exp0_q.delete();
        exp1_q.delete();
        cnt_m = 32'd0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 32'h00FF0000, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("rst_w0", out_data0, 32'h00000000);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("rst_w1", out_data0, 32'h0000FFFF);

        // Random traffic, including occasional clears and counter wrap
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
